stage_1_bool_nway: RTL
======================

Name: stage_1_bool_nway

Overview:
- Registered, parametrised successor to the first pipeline stage of the entropy encoder with Boolean parallelisation.
- Accepts one multi-symbol input word carrying NUM_LANES symbols and per-lane Boolean flags.
- Produces LUT values, range pre-shifts, the FL comparison, per-lane operand-isolation masks and a leading-Boolean lane count for stages 2/3.
- Adds a valid/ready handshake with a 2-entry skid buffer so downstream stalls no longer corrupt the pipeline.

Parameters:
RANGE_WIDTH, 16, width of FL/FH/UU/VV and of each op-iso mask
SYMBOL_WIDTH, 4, symbol width; NSYMS is SYMBOL_WIDTH+1 bits
LUT_ADDR_WIDTH, 8, LUT address width; must equal 2*SYMBOL_WIDTH
LUT_DATA_WIDTH, 16, LUT data width
NUM_LANES, 3, symbols per input word (1..8)
CNT_WIDTH, 4, width of lane_count; must be >= clog2(NUM_LANES+1)

Ports:
clk_stage_1  in  1  clock
reset  in  1  asynchronous active-high reset
in_valid  in  1  input word valid
in_ready  out  1  stage can accept a word
FL  in  RANGE_WIDTH  low CDF bound
FH  in  RANGE_WIDTH  high CDF bound
NSYMS  in  SYMBOL_WIDTH+1  symbols in alphabet
SYMBOL  in  NUM_LANES*SYMBOL_WIDTH  lane i at bits [i*SYMBOL_WIDTH +: SYMBOL_WIDTH]
bool_flag  in  NUM_LANES  per lane: 0 = Boolean symbol, 1 = not Boolean
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts
UU, VV  out  RANGE_WIDTH  FL>>6, FH>>6
COMP_mux_1  out  1  FL < 2^(RANGE_WIDTH-1)
lut_u_out, lut_v_out, lut_uv_out  out  LUT_DATA_WIDTH  LUT values and u-v
out_symbol  out  NUM_LANES*SYMBOL_WIDTH  registered SYMBOL
bool_out  out  NUM_LANES  inverted bool_flag (1 = Boolean)
op_iso  out  NUM_LANES*RANGE_WIDTH  lane i all-ones iff bool_out[0..i] are all 1, else 0
lane_count  out  CNT_WIDTH  number of leading Boolean lanes (0..NUM_LANES)
param_err  out  1  NSYMS==0, or NSYMS > 2^SYMBOL_WIDTH, or !bool_out[0] && SYMBOL[lane0] >= NSYMS

Behaviour:
- **Clock and reset.** One clock, clk_stage_1. reset is asynchronous and active-high.
- **Reset values.** out_valid=0. Every data output is 0 (op_iso=0, lane_count=0, param_err=0). Skid buffer is empty. in_ready=1 from the first edge after reset deasserts.
- **Combinational front end**, evaluated on the input word:
  - addr = {(NSYMS-1)[SYMBOL_WIDTH-1:0], SYMBOL lane0}; this drives lut_u_module and lut_v_module.
  - lut_uv = u - v, modulo 2^LUT_DATA_WIDTH.
  - op_iso and lane_count are prefix-AND / leading-ones of ~bool_flag.
  - All results are captured in one register set.
- **Transfers.**
  - Accept = in_valid && in_ready.
  - Emit = out_valid && out_ready.
  - Latency is 1 cycle: an accepted word appears on outputs the next cycle when the output register is free.
- **Storage.** Output register (main) plus one skid register.
- **State machine** (states EMPTY, ONE, FULL):
  - EMPTY: accept → load main, go to ONE.
  - ONE, emit without accept → EMPTY.
  - ONE, accept with emit → reload main, stay in ONE.
  - ONE, accept without emit → load skid, go to FULL.
  - FULL: in_ready=0. On emit → skid moves to main, go to ONE.
- **in_ready** is registered and equals (state != FULL).
- **Output stability.** While out_valid=1 and out_ready=0, every output is held stable.
- **Ordering.** Words leave in acceptance order; none are dropped or duplicated.
- **in_valid while in_ready=0** is ignored; the upstream must hold the word.
- **Reset mid-operation** discards both entries immediately and returns to EMPTY.
- **Boundary values.**
  - NSYMS=0 → addr uses (0-1) truncated = all-ones, and param_err=1; the word is still passed.
  - lane_count=NUM_LANES only when all flags are 0.
  - FL = 2^(RANGE_WIDTH-1) exactly → COMP_mux_1=0.
- **Disallowed configurations.** A parameter set with LUT_ADDR_WIDTH != 2*SYMBOL_WIDTH is illegal (elaboration-time check).

Test Plan:
- **Single word, flow-through.** Reset; out_ready=1; present FL=16'h4000, FH=16'h8000, NSYMS=5, SYMBOL=lane0 3, bool_flag=3'b111 → next cycle:
  - out_valid=1, UU=16'h0100, VV=16'h0200, COMP_mux_1=1;
  - lut address 8'h43, lane_count=0, op_iso all zero, param_err=0.
- **Boolean prefix.** bool_flag=3'b100 → bool_out=3'b011, lane_count=2, op_iso = {16'h0000, 16'hFFFF, 16'hFFFF}. bool_flag=3'b010 → lane_count=1, only lane0 mask set.
- **Backpressure.** out_ready=0; stream words A, B, C back-to-back →
  - A held in main, B in skid, in_ready=0 the cycle after B, C held by source.
  - Raise out_ready → A, B, C emitted in order, no duplicates.
- **Throughput.** out_ready=1 with continuous in_valid for 10 words → 10 outputs on consecutive cycles, in_ready never drops.
- **Errors and limits.**
  - NSYMS=0 → param_err=1.
  - NSYMS=17 → param_err=1.
  - NSYMS=4 with non-Boolean symbol 4 → param_err=1.
  - FL=16'h8000 → COMP_mux_1=0.
- **Reset mid-stall.** FULL state, assert reset asynchronously → out_valid=0 without a clock edge; after release in_ready=1 and no stale word is emitted.

Source files
------------

// File: rtl/stage_1_bool_nway.sv
// Entropy-encoder stage 1: LUT lookup, range pre-shifts and Boolean-lane masks for NUM_LANES symbols.
// Latency 1 cycle. A 2-entry main/skid buffer holds outputs stable while out_ready is low.

module lut_u_module #(
  parameter int SYMBOL_WIDTH   = 4,
  parameter int LUT_ADDR_WIDTH = 8,
  parameter int LUT_DATA_WIDTH = 16
) (
  input  logic [LUT_ADDR_WIDTH-1:0] addr,
  output logic [LUT_DATA_WIDTH-1:0] data
);
  localparam int TW = LUT_DATA_WIDTH + SYMBOL_WIDTH;

  // Lower CDF bound of symbol s in an alphabet of n = addr_hi+1 symbols: s * 2^(DW-2) / n
  logic [TW-1:0] num;
  logic [TW-1:0] den;

  assign num  = TW'(addr[SYMBOL_WIDTH-1:0]) << (LUT_DATA_WIDTH - 2);
  assign den  = TW'(addr[LUT_ADDR_WIDTH-1:SYMBOL_WIDTH]) + TW'(1);
  assign data = LUT_DATA_WIDTH'(num / den);
endmodule

module lut_v_module #(
  parameter int SYMBOL_WIDTH   = 4,
  parameter int LUT_ADDR_WIDTH = 8,
  parameter int LUT_DATA_WIDTH = 16
) (
  input  logic [LUT_ADDR_WIDTH-1:0] addr,
  output logic [LUT_DATA_WIDTH-1:0] data
);
  localparam int TW = LUT_DATA_WIDTH + SYMBOL_WIDTH;

  // Upper CDF bound: (s+1) * 2^(DW-2) / n
  logic [TW-1:0] num;
  logic [TW-1:0] den;

  assign num  = (TW'(addr[SYMBOL_WIDTH-1:0]) + TW'(1)) << (LUT_DATA_WIDTH - 2);
  assign den  = TW'(addr[LUT_ADDR_WIDTH-1:SYMBOL_WIDTH]) + TW'(1);
  assign data = LUT_DATA_WIDTH'(num / den);
endmodule

module stage_1_bool_nway #(
  parameter int RANGE_WIDTH    = 16,
  parameter int SYMBOL_WIDTH   = 4,
  parameter int LUT_ADDR_WIDTH = 8,
  parameter int LUT_DATA_WIDTH = 16,
  parameter int NUM_LANES      = 3,
  parameter int CNT_WIDTH      = 4
) (
  input  logic                              clk_stage_1,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [RANGE_WIDTH-1:0]            FL,
  input  logic [RANGE_WIDTH-1:0]            FH,
  input  logic [SYMBOL_WIDTH:0]             NSYMS,
  input  logic [NUM_LANES*SYMBOL_WIDTH-1:0] SYMBOL,
  input  logic [NUM_LANES-1:0]              bool_flag,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [RANGE_WIDTH-1:0]            UU,
  output logic [RANGE_WIDTH-1:0]            VV,
  output logic                              COMP_mux_1,
  output logic [LUT_DATA_WIDTH-1:0]         lut_u_out,
  output logic [LUT_DATA_WIDTH-1:0]         lut_v_out,
  output logic [LUT_DATA_WIDTH-1:0]         lut_uv_out,
  output logic [NUM_LANES*SYMBOL_WIDTH-1:0] out_symbol,
  output logic [NUM_LANES-1:0]              bool_out,
  output logic [NUM_LANES*RANGE_WIDTH-1:0]  op_iso,
  output logic [CNT_WIDTH-1:0]              lane_count,
  output logic                              param_err
);

  if (LUT_ADDR_WIDTH != 2*SYMBOL_WIDTH) begin : g_bad_lut_addr
    $error("stage_1_bool_nway: LUT_ADDR_WIDTH must equal 2*SYMBOL_WIDTH");
  end
  if (NUM_LANES < 1 || NUM_LANES > 8) begin : g_bad_lanes
    $error("stage_1_bool_nway: NUM_LANES must be 1..8");
  end
  if (CNT_WIDTH < $clog2(NUM_LANES+1)) begin : g_bad_cnt
    $error("stage_1_bool_nway: CNT_WIDTH too narrow for NUM_LANES");
  end

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [RANGE_WIDTH-1:0]            uu;
    logic [RANGE_WIDTH-1:0]            vv;
    logic                              comp;
    logic [LUT_DATA_WIDTH-1:0]         lut_u;
    logic [LUT_DATA_WIDTH-1:0]         lut_v;
    logic [LUT_DATA_WIDTH-1:0]         lut_uv;
    logic [NUM_LANES*SYMBOL_WIDTH-1:0] sym;
    logic [NUM_LANES-1:0]              bool_lane;
    logic [NUM_LANES*RANGE_WIDTH-1:0]  iso;
    logic [CNT_WIDTH-1:0]              cnt;
    logic                              err;
  } word_t;

  logic [SYMBOL_WIDTH-1:0]   sym0;
  logic [SYMBOL_WIDTH-1:0]   nsyms_m1;
  logic [LUT_ADDR_WIDTH-1:0] lut_addr;
  logic [LUT_DATA_WIDTH-1:0] lut_u;
  logic [LUT_DATA_WIDTH-1:0] lut_v;
  word_t                     in_w;

  state_t state_q, state_d;
  word_t  main_q, main_d;
  word_t  skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  logic   accept, emit;

  // NSYMS=0 wraps to all-ones in the address, matching the legacy stage
  assign sym0     = SYMBOL[SYMBOL_WIDTH-1:0];
  assign nsyms_m1 = SYMBOL_WIDTH'(NSYMS - {{SYMBOL_WIDTH{1'b0}}, 1'b1});
  assign lut_addr = {nsyms_m1, sym0};

  lut_u_module #(
    .SYMBOL_WIDTH  (SYMBOL_WIDTH),
    .LUT_ADDR_WIDTH(LUT_ADDR_WIDTH),
    .LUT_DATA_WIDTH(LUT_DATA_WIDTH)
  ) u_lut_u (
    .addr(lut_addr),
    .data(lut_u)
  );

  lut_v_module #(
    .SYMBOL_WIDTH  (SYMBOL_WIDTH),
    .LUT_ADDR_WIDTH(LUT_ADDR_WIDTH),
    .LUT_DATA_WIDTH(LUT_DATA_WIDTH)
  ) u_lut_v (
    .addr(lut_addr),
    .data(lut_v)
  );

  always_comb begin
    logic run;
    in_w           = '0;
    in_w.uu        = FL >> 6;
    in_w.vv        = FH >> 6;
    in_w.comp      = ~FL[RANGE_WIDTH-1];
    in_w.lut_u     = lut_u;
    in_w.lut_v     = lut_v;
    in_w.lut_uv    = lut_u - lut_v;
    in_w.sym       = SYMBOL;
    in_w.bool_lane = ~bool_flag;
    // Prefix-AND over Boolean lanes: masks and count stop at the first non-Boolean lane
    run = 1'b1;
    for (int i = 0; i < NUM_LANES; i++) begin
      run = run & ~bool_flag[i];
      in_w.iso[i*RANGE_WIDTH +: RANGE_WIDTH] = {RANGE_WIDTH{run}};
      if (run) begin
        in_w.cnt = in_w.cnt + CNT_WIDTH'(1);
      end
    end
    in_w.err = (NSYMS == '0)
            || (NSYMS[SYMBOL_WIDTH] && (NSYMS[SYMBOL_WIDTH-1:0] != '0))
            || (bool_flag[0] && ({1'b0, sym0} >= NSYMS));
  end

  assign accept = in_valid && in_ready_q;
  assign emit   = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_w;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && emit) begin
          main_d = in_w;
        end else if (accept) begin
          skid_d  = in_w;
          state_d = FULL;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk_stage_1 or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign UU         = main_q.uu;
  assign VV         = main_q.vv;
  assign COMP_mux_1 = main_q.comp;
  assign lut_u_out  = main_q.lut_u;
  assign lut_v_out  = main_q.lut_v;
  assign lut_uv_out = main_q.lut_uv;
  assign out_symbol = main_q.sym;
  assign bool_out   = main_q.bool_lane;
  assign op_iso     = main_q.iso;
  assign lane_count = main_q.cnt;
  assign param_err  = main_q.err;

endmodule
